// File: rtl/map_arb_pkg.sv
// Shared types and constants for the world-map read arbiter.
package map_arb_pkg;

  localparam int MAP_ADDR_W  = 14;
  localparam int MAP_COORD_W = 7;
  localparam int PIX_W       = 12;

  localparam logic [1:0] OOR_VALUE_DEF = 2'b11;

  typedef enum logic [2:0] {
    BOT_IDLE,
    BOT_WAIT,
    BOT_READ,
    BOT_ACK,
    BOT_HOLD
  } bot_state_e;

  // Per-request video tag carried alongside the BRAM read.
  typedef struct packed {
    logic             vld;
    logic             miss;
    logic             oor;
    logic [PIX_W-1:0] row;
    logic [PIX_W-1:0] col;
  } vid_tag_t;

endpackage

// File: rtl/map_arbiter_if.sv
// Video, bot and BRAM signal bundle of the map arbiter.
// The slave side is the arbiter; the master side is its environment.
interface map_arbiter_if;
  import map_arb_pkg::*;

  logic                   vid_req;
  logic [PIX_W-1:0]       vid_row;
  logic [PIX_W-1:0]       vid_col;
  logic                   vid_valid;
  logic [1:0]             vid_map_value;
  logic                   vid_miss;
  logic [PIX_W-1:0]       vid_row_q;
  logic [PIX_W-1:0]       vid_col_q;

  logic                   bot_req;
  logic [MAP_COORD_W-1:0] bot_locX;
  logic [MAP_COORD_W-1:0] bot_locY;
  logic                   bot_ack;
  logic [1:0]             bot_map_value;

  logic                   mem_en;
  logic [MAP_ADDR_W-1:0]  mem_addr;
  logic [1:0]             mem_data;

  modport slave (
    input  vid_req, vid_row, vid_col, bot_req, bot_locX, bot_locY, mem_data,
    output vid_valid, vid_map_value, vid_miss, vid_row_q, vid_col_q,
           bot_ack, bot_map_value, mem_en, mem_addr
  );

  modport master (
    output vid_req, vid_row, vid_col, bot_req, bot_locX, bot_locY, mem_data,
    input  vid_valid, vid_map_value, vid_miss, vid_row_q, vid_col_q,
           bot_ack, bot_map_value, mem_en, mem_addr
  );

endinterface

// File: rtl/map_pipe_delay.sv
// Two-stage register line aligning the video tag with BRAM read data.
// Latency 2 cycles, no stall: one tag in and one tag out every cycle.
module map_pipe_delay
  import map_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  vid_tag_t tag_i,
  output vid_tag_t tag_o
);

  vid_tag_t stage1_q;
  vid_tag_t stage2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= tag_i;
      stage2_q <= stage1_q;
    end
  end

  assign tag_o = stage2_q;

endmodule

// File: rtl/map_arbiter.sv
// Shares one BRAM read port between a fixed-latency video stream (result at N+2)
// and a bot requester; video wins the slot unless the bot has waited MAX_WAIT cycles.
module map_arbiter
  import map_arb_pkg::*;
#(
  parameter int         MAX_WAIT  = 1024,
  parameter logic [1:0] OOR_VALUE = OOR_VALUE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  map_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;

  bot_state_e              state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [MAP_ADDR_W-1:0]   bot_addr_q, bot_addr_d;
  logic [1:0]              bot_val_q, bot_val_d;
  logic [1:0]              mem_data_q;

  logic                    vid_inrange;
  logic                    force_slot;
  logic                    vid_own;
  logic                    bot_own;
  vid_tag_t                tag_in;
  vid_tag_t                tag_out;

  assign vid_inrange = ~|bus.vid_row[PIX_W-1:9] & ~|bus.vid_col[PIX_W-1:9];
  assign force_slot  = (state_q == BOT_WAIT) && (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
  assign vid_own     = bus.vid_req & vid_inrange & ~force_slot;
  assign bot_own     = (state_q == BOT_WAIT) & ~vid_own;

  assign bus.mem_en   = ~reset & (vid_own | bot_own);
  assign bus.mem_addr = reset   ? '0 :
                        vid_own ? {bus.vid_row[8:2], bus.vid_col[8:2]} :
                        bot_own ? bot_addr_q : '0;

  always_comb begin
    tag_in      = '0;
    tag_in.vld  = bus.vid_req;
    tag_in.miss = bus.vid_req & vid_inrange & force_slot;
    tag_in.oor  = bus.vid_req & ~vid_inrange;
    tag_in.row  = bus.vid_row;
    tag_in.col  = bus.vid_col;
  end

  map_pipe_delay u_pipe (
    .clk   (clk),
    .rst   (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Read data lands one cycle after the slot; hold it for the second pipe stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data_q <= '0;
    end else begin
      mem_data_q <= bus.mem_data;
    end
  end

  assign bus.vid_valid     = tag_out.vld;
  assign bus.vid_miss      = tag_out.vld & tag_out.miss;
  assign bus.vid_map_value = !tag_out.vld                  ? 2'b00 :
                             (tag_out.oor || tag_out.miss) ? OOR_VALUE : mem_data_q;
  assign bus.vid_row_q     = tag_out.row;
  assign bus.vid_col_q     = tag_out.col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOT_IDLE;
      wait_cnt_q <= '0;
      bot_addr_q <= '0;
      bot_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bot_addr_q <= bot_addr_d;
      bot_val_q  <= bot_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    bot_addr_d = bot_addr_q;
    bot_val_d  = bot_val_q;
    case (state_q)
      BOT_IDLE: begin
        if (bus.bot_req) begin
          state_d    = BOT_WAIT;
          bot_addr_d = {bus.bot_locY, bus.bot_locX};
        end
      end
      BOT_WAIT: begin
        if (bot_own) begin
          state_d = BOT_READ;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      BOT_READ: begin
        bot_val_d = bus.mem_data;
        state_d   = BOT_ACK;
      end
      BOT_ACK: begin
        state_d = bus.bot_req ? BOT_HOLD : BOT_IDLE;
      end
      // A request still held after its ack must drop before another is taken.
      BOT_HOLD: begin
        if (!bus.bot_req) begin
          state_d = BOT_IDLE;
        end
      end
      default: state_d = BOT_IDLE;
    endcase
  end

  assign bus.bot_ack       = (state_q == BOT_ACK);
  assign bus.bot_map_value = bot_val_q;

endmodule
